// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Purpose  : Arbitrates L1 I-cache and D-cache line misses onto one L2 port.
//            Define L2_ARB_ROUND_ROBIN_EN for round-robin ties instead of
//            fixed D priority with a starvation counter.
// Revision : 1.0 - initial release
// ============================================================================
module l2_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;
    localparam logic       c_OWNER_I = 1'b0;
    localparam logic       c_OWNER_D = 1'b1;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_owner;
    logic              r_op_write;
    logic [ADDR_W-5:0] r_line_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant;
    logic              w_win_d;
    logic              w_unused_addr_bits;

    assign w_req_i = i_pmem_read;
    assign w_req_d = d_pmem_read | d_pmem_write;
    assign w_grant = (r_state == S_IDLE) && (w_req_i || w_req_d);

    // Line-aligned addressing: the byte offset within a line never reaches L2.
    assign w_unused_addr_bits = ^{i_pmem_address[3:0], d_pmem_address[3:0]};

`ifdef L2_ARB_ROUND_ROBIN_EN
    logic r_rr_last;
    logic w_unused_starve;

    assign w_unused_starve = (STARVE_LIMIT != 0);
    // r_rr_last = 1 means D was granted last, so I wins the next tie.
    assign w_win_d = w_req_d && (!w_req_i || !r_rr_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_last <= c_OWNER_I;
        end else if (w_grant) begin
            r_rr_last <= w_win_d;
        end
    end
`else
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    assign w_win_d = w_req_d && (!w_req_i || (r_starve_cnt != c_STARVE_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_grant) begin
            if (w_win_d && w_req_i) begin
                if (r_starve_cnt != c_STARVE_MAX) begin
                    r_starve_cnt <= r_starve_cnt + 4'd1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req_i || w_req_d) w_next_state = S_BUSY;
            S_BUSY:  if (l2_resp) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Write wins when D raises read and write together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner     <= c_OWNER_I;
            r_op_write  <= 1'b0;
            r_line_addr <= '0;
            r_wdata     <= '0;
        end else if (w_grant) begin
            r_owner     <= w_win_d;
            r_op_write  <= w_win_d & d_pmem_write;
            r_line_addr <= w_win_d ? d_pmem_address[ADDR_W-1:4] : i_pmem_address[ADDR_W-1:4];
            r_wdata     <= (w_win_d & d_pmem_write) ? d_pmem_wdata : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if ((r_state == S_BUSY) && l2_resp) begin
            if (r_owner == c_OWNER_D) begin
                r_d_rdata <= l2_rdata;
            end else begin
                r_i_rdata <= l2_rdata;
            end
        end
    end

    always_comb begin
        l2_read     = 1'b0;
        l2_write    = 1'b0;
        l2_address  = '0;
        l2_wdata    = '0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        case (r_state)
            S_BUSY: begin
                l2_read    = ~r_op_write;
                l2_write   = r_op_write;
                l2_address = {r_line_addr, 4'b0000};
                l2_wdata   = r_wdata;
            end
            S_RESP: begin
                i_pmem_resp = (r_owner == c_OWNER_I);
                d_pmem_resp = (r_owner == c_OWNER_D);
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = r_i_rdata;
    assign d_pmem_rdata = r_d_rdata;

endmodule
`default_nettype wire
